// File: rtl/fb_pkg.sv
// Shared types and helpers for the double-buffered frame buffer.
// Holds FSM encodings, default geometry and a clog2 helper.
package fb_pkg;

    typedef enum logic [1:0] {
        RENDER    = 2'd0,
        WAIT_SWAP = 2'd1,
        CLEAR     = 2'd2
    } fb_state_e;

    localparam int FB_FRAME_W = 640;
    localparam int FB_FRAME_H = 480;
    localparam int FB_PIXEL_W = 3;

    function automatic int clog2(input int v);
        int r;
        int n;
        r = 0;
        n = v - 1;
        while (n > 0) begin
            r++;
            n = n >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/frame_buffer_dbl_if.sv
// Renderer/display bus of the double-buffered frame buffer.
// master = renderer+display side, slave = frame buffer.
interface frame_buffer_dbl_if #(
    parameter int PIXEL_W = 3,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
) ();

    logic               wr_en;
    logic [X_W-1:0]     wr_x;
    logic [Y_W-1:0]     wr_y;
    logic [PIXEL_W-1:0] wr_data;
    logic               wr_ready;
    logic               wr_frame_done;
    logic               wr_overflow;
    logic               rd_en;
    logic [X_W-1:0]     rd_x;
    logic [Y_W-1:0]     rd_y;
    logic [PIXEL_W-1:0] rd_data;
    logic               rd_valid;
    logic               rd_frame_start;
    logic               front_bank;
    logic               swap_pending;

    modport master (
        output wr_en, wr_x, wr_y, wr_data, wr_frame_done,
        output rd_en, rd_x, rd_y, rd_frame_start,
        input  wr_ready, wr_overflow, rd_data, rd_valid,
        input  front_bank, swap_pending
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_data, wr_frame_done,
        input  rd_en, rd_x, rd_y, rd_frame_start,
        output wr_ready, wr_overflow, rd_data, rd_valid,
        output front_bank, swap_pending
    );

endinterface

// File: rtl/fb_bank_ram.sv
// One pixel bank: simple dual-port RAM, registered read.
// The array is never reset; contents survive rst_n.
module fb_bank_ram
    import fb_pkg::*;
#(
    parameter int PIXEL_W = 3,
    parameter int DEPTH   = 307200,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [PIXEL_W-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [PIXEL_W-1:0] rdata
);

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic [PIXEL_W-1:0] rdata_q;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port, output holds when re is low
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// Ping-pong pixel frame buffer: renderer fills the back bank,
// display reads the front bank, swap only at vsync handshake.
module frame_buffer_dbl
    import fb_pkg::*;
#(
    parameter int                 PIXEL_W   = FB_PIXEL_W,
    parameter int                 FRAME_W   = FB_FRAME_W,
    parameter int                 FRAME_H   = FB_FRAME_H,
    parameter int                 X_W       = 10,
    parameter int                 Y_W       = 9,
    parameter int                 CLEAR_EN  = 1,
    parameter logic [PIXEL_W-1:0] CLEAR_VAL = '0
) (
    input logic               clk,
    input logic               rst_n,
    frame_buffer_dbl_if.slave bus
);

    localparam int DEPTH  = FRAME_W * FRAME_H;
    localparam int ADDR_W = clog2(DEPTH);

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ROW   = ADDR_W'(FRAME_W);
    localparam logic [X_W:0]      X_LIM = (X_W + 1)'(FRAME_W);
    localparam logic [Y_W:0]      Y_LIM = (Y_W + 1)'(FRAME_H);

    if (FRAME_W > (1 << X_W) || FRAME_H > (1 << Y_W)) begin : g_bad_geom
        $error("frame_buffer_dbl: X_W/Y_W too narrow for frame");
    end

    fb_state_e          state_q, state_d;
    logic               front_q, front_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic               wr_ready_q, wr_ready_d;
    logic               swap_pend_q, swap_pend_d;
    logic               ovf_q, ovf_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_zero_q, rd_zero_d;
    logic               rd_bank_q, rd_bank_d;

    logic               wr_in_rng, rd_in_rng;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;
    logic               wr_fire, clr_fire;
    logic               bank_we;
    logic [ADDR_W-1:0]  bank_waddr;
    logic [PIXEL_W-1:0] bank_wdata;
    logic [PIXEL_W-1:0] rdata0, rdata1;

    assign wr_in_rng = ({1'b0, bus.wr_x} < X_LIM) &&
                       ({1'b0, bus.wr_y} < Y_LIM);
    assign rd_in_rng = ({1'b0, bus.rd_x} < X_LIM) &&
                       ({1'b0, bus.rd_y} < Y_LIM);

    assign wr_addr = ADDR_W'(bus.wr_y) * ROW + ADDR_W'(bus.wr_x);
    assign rd_addr = ADDR_W'(bus.rd_y) * ROW + ADDR_W'(bus.rd_x);

    assign wr_fire    = bus.wr_en && wr_ready_q && wr_in_rng;
    assign clr_fire   = (state_q == CLEAR);
    assign bank_we    = wr_fire || clr_fire;
    assign bank_waddr = clr_fire ? clr_cnt_q : wr_addr;
    assign bank_wdata = clr_fire ? CLEAR_VAL : bus.wr_data;

    // Swap FSM, clear sequencer and read-side bookkeeping
    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        clr_cnt_d   = clr_cnt_q;
        ovf_d       = ovf_q || (bus.wr_en && !wr_ready_q);
        rd_valid_d  = bus.rd_en;
        rd_zero_d   = bus.rd_en ? !rd_in_rng : rd_zero_q;
        rd_bank_d   = bus.rd_en ? front_q : rd_bank_q;
        unique case (1'b1)
            (state_q == RENDER): begin
                if (bus.wr_frame_done) begin
                    state_d = WAIT_SWAP;
                end
            end
            (state_q == WAIT_SWAP): begin
                if (bus.rd_frame_start) begin
                    front_d = !front_q;
                    state_d = (CLEAR_EN != 0) ? CLEAR : RENDER;
                end
            end
            (state_q == CLEAR): begin
                if (clr_cnt_q == LAST) begin
                    clr_cnt_d = '0;
                    state_d   = RENDER;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RENDER;
            end
        endcase
        wr_ready_d  = (state_d == RENDER);
        swap_pend_d = (state_d == WAIT_SWAP);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RENDER;
            front_q     <= 1'b0;
            clr_cnt_q   <= '0;
            wr_ready_q  <= 1'b0;
            swap_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_zero_q   <= 1'b1;
            rd_bank_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            clr_cnt_q   <= clr_cnt_d;
            wr_ready_q  <= wr_ready_d;
            swap_pend_q <= swap_pend_d;
            ovf_q       <= ovf_d;
            rd_valid_q  <= rd_valid_d;
            rd_zero_q   <= rd_zero_d;
            rd_bank_q   <= rd_bank_d;
        end
    end

    fb_bank_ram #(
        .PIXEL_W (PIXEL_W),
        .DEPTH   (DEPTH)
    ) u_bank0 (
        .clk   (clk),
        .we    (bank_we && front_q),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (bus.rd_en && rd_in_rng && !front_q),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    fb_bank_ram #(
        .PIXEL_W (PIXEL_W),
        .DEPTH   (DEPTH)
    ) u_bank1 (
        .clk   (clk),
        .we    (bank_we && !front_q),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (bus.rd_en && rd_in_rng && front_q),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    assign bus.wr_ready     = wr_ready_q;
    assign bus.wr_overflow  = ovf_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_zero_q ? '0 :
                              (rd_bank_q ? rdata1 : rdata0);
    assign bus.front_bank   = front_q;
    assign bus.swap_pending = swap_pend_q;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Scoreboard bench for frame_buffer_dbl on an 8x4 frame
// with clear enabled (clear value 5).
module tb_frame_buffer_dbl;

    localparam int PW = 3;
    localparam int FW = 8;
    localparam int FH = 4;
    localparam int XW = 4;
    localparam int YW = 3;
    localparam logic [PW-1:0] CV = 3'd5;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    frame_buffer_dbl_if #(.PIXEL_W(PW), .X_W(XW), .Y_W(YW)) bus ();

    frame_buffer_dbl #(
        .PIXEL_W   (PW),
        .FRAME_W   (FW),
        .FRAME_H   (FH),
        .X_W       (XW),
        .Y_W       (YW),
        .CLEAR_EN  (1),
        .CLEAR_VAL (CV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    logic [PW-1:0] mdl [2][FW*FH];
    logic          fb_m;
    logic [PW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: every valid read pops one expected pixel
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0)
                check("rd_unexpected", 32'd1, 32'd0);
            else
                check("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic wr(input int x, input int y, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_x    = XW'(x);
        bus.wr_y    = YW'(y);
        bus.wr_data = PW'(d);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input int x, input int y);
        bus.rd_en = 1'b1;
        bus.rd_x  = XW'(x);
        bus.rd_y  = YW'(y);
        if (x < FW && y < FH)
            exp_q.push_back(mdl[fb_m][y*FW+x]);
        else
            exp_q.push_back('0);
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic rd_all();
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                rd(x, y);
    endtask

    task automatic wait_ready(input string tag, input int exp_n);
        int n;
        n = 0;
        while (bus.wr_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic set_bank(input int b, input int v);
        for (int i = 0; i < FW*FH; i++)
            mdl[b][i] = PW'(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        fb_m               = 1'b0;
        bus.wr_en          = 1'b0;
        bus.wr_x           = '0;
        bus.wr_y           = '0;
        bus.wr_data        = '0;
        bus.wr_frame_done  = 1'b0;
        bus.rd_en          = 1'b0;
        bus.rd_x           = '0;
        bus.rd_y           = '0;
        bus.rd_frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_front", 32'(bus.front_bank), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_overflow", 32'(bus.wr_overflow), 32'd0);
        check("rst_swap_pend", 32'(bus.swap_pending), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_after_rst", 32'(bus.wr_ready), 32'd1);

        // fill back bank 1 with (x+y)%8
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) begin
                wr(x, y, (x + y) % 8);
                mdl[1][y*FW+x] = PW'((x + y) % 8);
            end
        bus.wr_frame_done = 1'b1;
        @(negedge clk);
        bus.wr_frame_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("swap_pend_wait", 32'(bus.swap_pending), 32'd1);
            check("wr_ready_wait", 32'(bus.wr_ready), 32'd0);
            if (i < 2) @(negedge clk);
        end
        bus.rd_frame_start = 1'b1;
        @(negedge clk);
        bus.rd_frame_start = 1'b0;
        fb_m = 1'b1;
        check("swap1_front", 32'(bus.front_bank), 32'd1);
        check("swap1_pend", 32'(bus.swap_pending), 32'd0);
        wait_ready("clear1_len", 32);
        set_bank(0, CV);

        rd_all();
        @(negedge clk);
        check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("idle_rd_hold", 32'(bus.rd_data), 32'd2);

        // out-of-range write and read
        wr(8, 0, 3);
        check("oor_wr_overflow", 32'(bus.wr_overflow), 32'd0);
        rd(0, 4);
        @(negedge clk);

        // dropped write while waiting for swap
        bus.wr_frame_done = 1'b1;
        @(negedge clk);
        bus.wr_frame_done = 1'b0;
        wr(1, 1, 7);
        check("drop_overflow", 32'(bus.wr_overflow), 32'd1);
        bus.wr_frame_done = 1'b1;
        @(negedge clk);
        bus.wr_frame_done = 1'b0;
        check("redone_pend", 32'(bus.swap_pending), 32'd1);
        check("redone_front", 32'(bus.front_bank), 32'd1);

        // read in the swap cycle, then again after
        bus.rd_frame_start = 1'b1;
        rd(2, 2);
        bus.rd_frame_start = 1'b0;
        fb_m = 1'b0;
        check("swap2_front", 32'(bus.front_bank), 32'd0);
        rd(2, 2);
        wait_ready("clear2_len", 31);
        set_bank(1, CV);
        rd_all();
        @(negedge clk);
        check("overflow_sticky", 32'(bus.wr_overflow), 32'd1);

        // rd_frame_start in RENDER is ignored, also with frame done
        bus.rd_frame_start = 1'b1;
        @(negedge clk);
        bus.rd_frame_start = 1'b0;
        check("render_rfs_front", 32'(bus.front_bank), 32'd0);
        check("render_rfs_pend", 32'(bus.swap_pending), 32'd0);
        bus.rd_frame_start = 1'b1;
        bus.wr_frame_done  = 1'b1;
        @(negedge clk);
        bus.rd_frame_start = 1'b0;
        bus.wr_frame_done  = 1'b0;
        check("coinc_front", 32'(bus.front_bank), 32'd0);
        check("coinc_pend", 32'(bus.swap_pending), 32'd1);
        bus.rd_frame_start = 1'b1;
        @(negedge clk);
        bus.rd_frame_start = 1'b0;
        fb_m = 1'b1;
        check("swap3_front", 32'(bus.front_bank), 32'd1);
        rd(2, 2);
        rd(5, 3);
        wait_ready("clear3_len", 30);
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
